// File: rtl/galaga_pkg.sv
// Shared constants and types for the Galaga-style player/bullet datapath.
// Slot layout: each slot packs x in the low field and y in the high field.
package galaga_pkg;

    localparam int unsigned NumSlots = 15;
    localparam int unsigned IdxW     = 4;
    localparam int unsigned SlotW    = 19;
    localparam int unsigned XOff     = 0;
    localparam int unsigned XW       = 10;
    localparam int unsigned YOff     = 10;
    localparam int unsigned YW       = 9;

    localparam int unsigned PlayerW  = 24;
    localparam int unsigned BulletW  = 4;
    localparam int unsigned BulletH  = 16;
    localparam int unsigned PlayerY  = 280;

    typedef enum logic [1:0] {
        StIdle,
        StMove,
        StSpawn
    } bullet_fsm_e;

endpackage

// File: rtl/slot_priority_enc.sv
// Combinational lowest-index free-slot finder for bullet spawning.
module slot_priority_enc
    import galaga_pkg::*;
#(
    parameter int unsigned N  = NumSlots,
    parameter int unsigned IW = IdxW
) (
    input  logic [N-1:0]  free_mask,
    output logic [IW-1:0] idx,
    output logic          found
);

    // Scan downward so the last hit written is the lowest free index.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (free_mask[i]) begin
                idx   = IW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/player_bullet_ctrl.sv
// Player-bullet slot controller: per-frame move sweep over all slots, then an
// optional cooldown-gated spawn. Outputs are in the renderer's packed format.
module player_bullet_ctrl
    import galaga_pkg::*;
#(
    parameter int unsigned NUM_SLOTS       = NumSlots,
    parameter int unsigned BULLET_SPEED    = 4,
    parameter int unsigned COOLDOWN_FRAMES = 8,
    parameter int unsigned PLAYER_Y        = PlayerY,
    parameter int unsigned PLAYER_W        = PlayerW,
    parameter int unsigned BULLET_W        = BulletW,
    parameter int unsigned BULLET_H        = BulletH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frameTick,
    input  logic                       fireReq,
    input  logic                       playerState,
    input  logic [XW-1:0]              playerPosition,
    input  logic [NUM_SLOTS-1:0]       hitClear,
    output logic [NUM_SLOTS-1:0]       playerBulletState,
    output logic [NUM_SLOTS*SlotW-1:0] playerBulletPosition,
    output logic                       busy,
    output logic                       fireAck,
    output logic                       frameOverrun
);

    localparam int unsigned CoolW    = $clog2(COOLDOWN_FRAMES + 1);
    localparam int unsigned XSumW    = XW + 1;
    localparam logic [XSumW-1:0] SpawnXOff = XSumW'((PLAYER_W - BULLET_W) / 2);
    localparam logic [YW-1:0]    SpawnY    = YW'(PLAYER_Y - BULLET_H);
    localparam logic [YW-1:0]    Speed     = YW'(BULLET_SPEED);
    localparam logic [CoolW-1:0] CoolLoad  = CoolW'(COOLDOWN_FRAMES);
    localparam logic [IdxW-1:0]  LastIdx   = IdxW'(NUM_SLOTS - 1);

    bullet_fsm_e           fsm_q, fsm_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [CoolW-1:0]      cool_q, cool_d;
    logic [NUM_SLOTS-1:0]  st_q, st_d;
    logic [XW-1:0]         x_q [NUM_SLOTS];
    logic [XW-1:0]         x_d [NUM_SLOTS];
    logic [YW-1:0]         y_q [NUM_SLOTS];
    logic [YW-1:0]         y_d [NUM_SLOTS];
    logic                  busy_q, busy_d;
    logic                  ack_q, ack_d;
    logic                  ovr_q, ovr_d;

    logic [IdxW-1:0]       free_idx;
    logic                  free_found;
    logic                  spawn_ok;
    logic [XSumW-1:0]      x_sum;
    logic [XW-1:0]         spawn_x;

    slot_priority_enc #(
        .N  (NUM_SLOTS),
        .IW (IdxW)
    ) u_enc (
        .free_mask (~st_q),
        .idx       (free_idx),
        .found     (free_found)
    );

    assign x_sum    = {1'b0, playerPosition} + SpawnXOff;
    assign spawn_x  = x_sum[XW] ? '1 : x_sum[XW-1:0];
    assign spawn_ok = fireReq && playerState && (cool_q == '0) && free_found;

    always_comb begin
        fsm_d  = fsm_q;
        idx_d  = idx_q;
        cool_d = cool_q;
        st_d   = st_q;
        x_d    = x_q;
        y_d    = y_q;
        ack_d  = 1'b0;
        ovr_d  = ovr_q;

        unique case (fsm_q)
            StIdle: begin
                if (frameTick) begin
                    fsm_d = StMove;
                    idx_d = '0;
                end
            end
            StMove: begin
                if (st_q[idx_q]) begin
                    if (y_q[idx_q] < Speed) begin
                        st_d[idx_q] = 1'b0;
                        x_d[idx_q]  = '0;
                        y_d[idx_q]  = '0;
                    end else begin
                        y_d[idx_q] = y_q[idx_q] - Speed;
                    end
                end
                if (idx_q == LastIdx) begin
                    fsm_d = StSpawn;
                    idx_d = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StSpawn: begin
                fsm_d = StIdle;
                if (spawn_ok) begin
                    st_d[free_idx] = 1'b1;
                    x_d[free_idx]  = spawn_x;
                    y_d[free_idx]  = SpawnY;
                    cool_d         = CoolLoad;
                    ack_d          = 1'b1;
                end else if (cool_q != '0) begin
                    cool_d = cool_q - 1'b1;
                end
            end
            default: fsm_d = StIdle;
        endcase

        if (frameTick && (fsm_q != StIdle)) begin
            ovr_d = 1'b1;
        end

        // Kills apply only to slots live at cycle start, so a same-cycle spawn survives.
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (hitClear[i] && st_q[i]) begin
                st_d[i] = 1'b0;
                x_d[i]  = '0;
                y_d[i]  = '0;
            end
        end

        busy_d = (fsm_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q  <= StIdle;
            idx_q  <= '0;
            cool_q <= '0;
            st_q   <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
            busy_q <= 1'b0;
            ack_q  <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            idx_q  <= idx_d;
            cool_q <= cool_d;
            st_q   <= st_d;
            x_q    <= x_d;
            y_q    <= y_d;
            busy_q <= busy_d;
            ack_q  <= ack_d;
            ovr_q  <= ovr_d;
        end
    end

    always_comb begin
        playerBulletPosition = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            playerBulletPosition[i*SlotW + XOff +: XW] = x_q[i];
            playerBulletPosition[i*SlotW + YOff +: YW] = y_q[i];
        end
    end

    assign playerBulletState = st_q;
    assign busy              = busy_q;
    assign fireAck           = ack_q;
    assign frameOverrun      = ovr_q;

endmodule

// File: tb/tb_player_bullet_ctrl.sv
// Bench for player_bullet_ctrl: two instances (default and short-cooldown/odd spawn row)
// share stimulus; a per-frame reference model feeds an expectation queue.
module tb_player_bullet_ctrl;
    import galaga_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         frameTick;
    logic         fireReq;
    logic         playerState;
    logic [9:0]   playerPosition;
    logic [14:0]  hitClear;

    logic [14:0]  st_a, st_b;
    logic [284:0] pos_a, pos_b;
    logic         busy_a, busy_b, ack_a, ack_b, ovr_a, ovr_b;

    player_bullet_ctrl dut_a (
        .clk                  (clk),
        .rst                  (rst),
        .frameTick            (frameTick),
        .fireReq              (fireReq),
        .playerState          (playerState),
        .playerPosition       (playerPosition),
        .hitClear             (hitClear),
        .playerBulletState    (st_a),
        .playerBulletPosition (pos_a),
        .busy                 (busy_a),
        .fireAck              (ack_a),
        .frameOverrun         (ovr_a)
    );

    player_bullet_ctrl #(
        .COOLDOWN_FRAMES (1),
        .PLAYER_Y        (279)
    ) dut_b (
        .clk                  (clk),
        .rst                  (rst),
        .frameTick            (frameTick),
        .fireReq              (fireReq),
        .playerState          (playerState),
        .playerPosition       (playerPosition),
        .hitClear             (hitClear),
        .playerBulletState    (st_b),
        .playerBulletPosition (pos_b),
        .busy                 (busy_b),
        .fireAck              (ack_b),
        .frameOverrun         (ovr_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    localparam int KSlot = 0;
    localparam int KAck  = 1;
    localparam int KBusy = 2;
    localparam int KOvr  = 3;

    typedef struct {
        int          dut;
        int          kind;
        int          slot;
        int          ph;
        logic [19:0] exp;
        string       tag;
    } exp_t;

    exp_t sb[$];

    // Reference model state, one row per instance
    logic [14:0] m_st [2];
    logic [9:0]  m_x  [2][15];
    logic [8:0]  m_y  [2][15];
    int          m_cool [2];
    bit          m_ovr  [2];
    bit          m_ack  [2];
    int          cool_frames [2] = '{8, 1};
    int          spawn_y     [2] = '{264, 263};

    logic [14:0] hit_plan  [17];
    bit          tick_plan [17];
    int          fno = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] slot_val(input bit s, input int y, input int x);
        return {s, 9'(y), 10'(x)};
    endfunction

    function automatic logic [19:0] observe(input int d, input int kind, input int s);
        logic [14:0]  st;
        logic [284:0] pos;
        st  = (d == 0) ? st_a : st_b;
        pos = (d == 0) ? pos_a : pos_b;
        case (kind)
            KSlot:   return {st[s], pos[s*19+10 +: 9], pos[s*19 +: 10]};
            KAck:    return 20'((d == 0) ? ack_a : ack_b);
            KBusy:   return 20'((d == 0) ? busy_a : busy_b);
            default: return 20'((d == 0) ? ovr_a : ovr_b);
        endcase
    endfunction

    function automatic void push(input int d, input int kind, input int s, input int ph,
                                 input logic [19:0] exp, input string tag);
        exp_t e;
        e.dut = d; e.kind = kind; e.slot = s; e.ph = ph; e.exp = exp; e.tag = tag;
        sb.push_back(e);
    endfunction

    task automatic drain(input int ph);
        exp_t e;
        if (sb.size() == 0) check($sformatf("f%0d_sb_empty_ph%0d", fno, ph), 32'd0, 32'd1);
        while (sb.size() > 0 && sb[0].ph == ph) begin
            e = sb.pop_front();
            check(e.tag, 32'(observe(e.dut, e.kind, e.slot)), 32'(e.exp));
        end
    endtask

    task automatic check_slot(input string tag, input int d, input int s, input logic [19:0] v);
        check(tag, 32'(observe(d, KSlot, s)), 32'(v));
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_st[d] = '0;
            m_cool[d] = 0;
            m_ovr[d] = 1'b0;
            for (int j = 0; j < 15; j++) begin
                m_x[d][j] = '0;
                m_y[d][j] = '0;
            end
        end
    endfunction

    // Steps the model through one 16-edge frame using current inputs and plans.
    function automatic void model_frame();
        logic [14:0] st0;
        bit          placed;
        int          xs;
        for (int d = 0; d < 2; d++) begin
            m_ack[d] = 1'b0;
            for (int c = 1; c <= 16; c++) begin
                st0 = m_st[d];
                if (c <= 15) begin
                    if (st0[c-1]) begin
                        if (m_y[d][c-1] < 9'd4) begin
                            m_st[d][c-1] = 1'b0;
                            m_x[d][c-1]  = '0;
                            m_y[d][c-1]  = '0;
                        end else begin
                            m_y[d][c-1] = m_y[d][c-1] - 9'd4;
                        end
                    end
                end else if (fireReq && playerState && m_cool[d] == 0 && st0 != 15'h7fff) begin
                    xs = int'(playerPosition) + 10;
                    if (xs > 1023) xs = 1023;
                    placed = 1'b0;
                    for (int j = 0; j < 15; j++) begin
                        if (!st0[j] && !placed) begin
                            m_st[d][j] = 1'b1;
                            m_x[d][j]  = 10'(xs);
                            m_y[d][j]  = 9'(spawn_y[d]);
                            placed     = 1'b1;
                        end
                    end
                    m_cool[d] = cool_frames[d];
                    m_ack[d]  = 1'b1;
                end else if (m_cool[d] > 0) begin
                    m_cool[d]--;
                end
                for (int j = 0; j < 15; j++) begin
                    if (hit_plan[c][j] && st0[j]) begin
                        m_st[d][j] = 1'b0;
                        m_x[d][j]  = '0;
                        m_y[d][j]  = '0;
                    end
                end
                if (tick_plan[c]) m_ovr[d] = 1'b1;
            end
        end
    endfunction

    task automatic run_frame();
        for (int d = 0; d < 2; d++) begin
            push(d, KBusy, 0, 1, 20'd1, $sformatf("f%0d_d%0d_busy_start", fno, d));
            push(d, KAck,  0, 1, 20'd0, $sformatf("f%0d_d%0d_ack_start", fno, d));
        end
        model_frame();
        for (int d = 0; d < 2; d++) begin
            for (int s = 0; s < 15; s++) begin
                push(d, KSlot, s, 2, {m_st[d][s], m_y[d][s], m_x[d][s]},
                     $sformatf("f%0d_d%0d_slot%0d", fno, d, s));
            end
            push(d, KAck,  0, 2, 20'(m_ack[d]), $sformatf("f%0d_d%0d_ack_end", fno, d));
            push(d, KBusy, 0, 2, 20'd0, $sformatf("f%0d_d%0d_busy_end", fno, d));
            push(d, KOvr,  0, 2, 20'(m_ovr[d]), $sformatf("f%0d_d%0d_overrun", fno, d));
        end
        frameTick = 1'b1;
        hitClear  = '0;
        @(negedge clk);
        frameTick = tick_plan[1];
        hitClear  = hit_plan[1];
        drain(1);
        for (int c = 2; c <= 16; c++) begin
            @(negedge clk);
            frameTick = tick_plan[c];
            hitClear  = hit_plan[c];
        end
        @(negedge clk);
        frameTick = 1'b0;
        hitClear  = '0;
        drain(2);
        for (int c = 0; c <= 16; c++) begin
            hit_plan[c]  = '0;
            tick_plan[c] = 1'b0;
        end
        fno++;
    endtask

    initial begin
        rst = 1'b1;
        frameTick = 1'b0;
        fireReq = 1'b0;
        playerState = 1'b0;
        playerPosition = '0;
        hitClear = '0;
        for (int c = 0; c <= 16; c++) begin
            hit_plan[c]  = '0;
            tick_plan[c] = 1'b0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("idle_state_a", 32'(st_a), 32'd0);
        check("idle_pos_a", 32'(pos_a != '0), 32'd0);
        check("idle_busy_a", 32'(busy_a), 32'd0);
        check("idle_ack_a", 32'(ack_a), 32'd0);
        check("idle_ovr_a", 32'(ovr_a), 32'd0);
        check("idle_state_b", 32'(st_b), 32'd0);
        check("idle_pos_b", 32'(pos_b != '0), 32'd0);

        playerState = 1'b1;
        for (int f = 0; f <= 76; f++) begin
            fireReq        = (f <= 31);
            playerPosition = (f < 19) ? 10'd100 : 10'd1020;
            if (f == 31) begin
                hit_plan[1]  = 15'h0001;
                hit_plan[4]  = 15'h0008;
                hit_plan[16] = 15'h0001;
            end
            if (f == 32) tick_plan[5] = 1'b1;
            run_frame();
            if (f == 0) begin
                check_slot("first_spawn_a", 0, 0, slot_val(1, 264, 110));
                check_slot("first_spawn_b", 1, 0, slot_val(1, 263, 110));
                check("first_ack_a", 32'(ack_a), 32'd1);
            end
            if (f == 1) check_slot("first_move_a", 0, 0, slot_val(1, 260, 110));
            if (f == 9) check_slot("cool_spawn9_a", 0, 1, slot_val(1, 264, 110));
            if (f == 18) check_slot("cool_spawn18_a", 0, 2, slot_val(1, 264, 110));
            if (f == 27) check_slot("sat_x_a", 0, 3, slot_val(1, 264, 1023));
            if (f == 30) begin
                check("full_state_b", 32'(st_b), 32'h7fff);
                check("full_noack_b", 32'(ack_b), 32'd0);
            end
            if (f == 31) begin
                check_slot("hit_move3_a", 0, 3, slot_val(0, 0, 0));
                check_slot("hit_move3_b", 1, 3, slot_val(0, 0, 0));
                check_slot("hit_move0_a", 0, 0, slot_val(0, 0, 0));
                check_slot("hit_spawn0_b", 1, 0, slot_val(1, 263, 1023));
                check("hit_spawn_ack_b", 32'(ack_b), 32'd1);
            end
            if (f == 32) begin
                check("overrun_a", 32'(ovr_a), 32'd1);
                check("overrun_b", 32'(ovr_b), 32'd1);
            end
            if (f == 67) check_slot("y3_alive_b", 1, 1, slot_val(1, 3, 110));
            if (f == 68) check_slot("y3_cleared_b", 1, 1, slot_val(0, 0, 0));
            if (f == 74) check_slot("y4_alive_a", 0, 1, slot_val(1, 4, 110));
            if (f == 75) check_slot("y0_alive_a", 0, 1, slot_val(1, 0, 110));
            if (f == 76) check_slot("y0_cleared_a", 0, 1, slot_val(0, 0, 0));
        end

        // Mid-frame reset: asynchronous clear while the sweep is in flight
        fireReq = 1'b1;
        playerPosition = 10'd100;
        frameTick = 1'b1;
        @(negedge clk);
        frameTick = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_rst_busy_a", 32'(busy_a), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_state_a", 32'(st_a), 32'd0);
        check("rst_pos_a", 32'(pos_a != '0), 32'd0);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_ovr_a", 32'(ovr_a), 32'd0);
        check("rst_state_b", 32'(st_b), 32'd0);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        check("rst_ovr_b", 32'(ovr_b), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        run_frame();
        check_slot("post_rst_spawn_a", 0, 0, slot_val(1, 264, 110));
        check_slot("post_rst_spawn_b", 1, 0, slot_val(1, 263, 110));
        @(negedge clk);
        check("ack_one_cycle_a", 32'(ack_a), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
